// File: rtl/low_bus_arbiter_pkg.sv
// Shared low-bus constants: FSM state encoding, burst command byte, burst unit size.
// Imported by the arbiter and by the burst assembler so both parse packets identically.
package low_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_ADDR_HI = 3'd3,
        ST_LEN     = 3'd4,
        ST_DATA    = 3'd5,
        ST_ORDER   = 3'd6
    } state_e;

    localparam logic [7:0] CMD_DATA_TRAN_DEF  = 8'hA5;
    localparam int         BRUST_SIZE_LOG_DEF = 2;

    function automatic int burst_unit_bytes(input int size_log);
        return 1 << size_log;
    endfunction

endpackage

// File: rtl/low_bus_arbiter_if.sv
// Requester streams in, arbitrated byte stream out; master = requester/assembler side.
// No latency of its own; req_ready carries the per-requester backpressure.
interface low_bus_arbiter_if #(
    parameter int N_REQ          = 4,
    parameter int LOW_DATA_WIDTH = 8
);
    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ*LOW_DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]                req_ready;
    logic                            low_read_valid;
    logic [LOW_DATA_WIDTH-1:0]       low_read_data;
    logic [N_REQ-1:0]                grant;
    logic                            busy;
    logic                            abort;

    modport master (
        output req_valid, req_data,
        input  req_ready, low_read_valid, low_read_data, grant, busy, abort
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, low_read_valid, low_read_data, grant, busy, abort
    );
endinterface

// File: rtl/low_bus_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping modulo N_REQ.
// Purely combinational; no backpressure.
module rr_pick #(
    parameter  int N_REQ = 4,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);
    int w_j;

    // Walk from the farthest offset down so the closest hit to i_ptr wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_j = (int'(i_ptr) + k) % N_REQ;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
                o_any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/low_bus_arbiter.sv
// Packet-atomic round-robin arbiter for the byte-wide low bus, with a stall watchdog.
// Output byte lags acceptance by 1 cycle; req_ready is combinational, only to the owner.
module low_bus_arbiter
    import low_bus_pkg::*;
#(
    parameter int         LOW_DATA_WIDTH = 8,
    parameter int         BRUST_SIZE_LOG = BRUST_SIZE_LOG_DEF,
    parameter int         N_REQ          = 4,
    parameter logic [7:0] CMD_DATA_TRAN  = CMD_DATA_TRAN_DEF,
    parameter int         TIMEOUT        = 255
) (
    input  logic             clk,
    input  logic             rst,
    low_bus_arbiter_if.slave bus
);
    localparam int IW         = $clog2(N_REQ);
    localparam int CW         = 8 + BRUST_SIZE_LOG + 1;
    localparam int SW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int UNIT_BYTES = burst_unit_bytes(BRUST_SIZE_LOG);

    state_e                    r_state, w_state_nxt;
    logic [N_REQ-1:0]          r_grant;
    logic [IW-1:0]             r_idx, r_rr_ptr;
    logic [7:0]                r_len;
    logic [CW-1:0]             r_byte_cnt;
    logic [SW-1:0]             r_stall_cnt;
    logic                      r_out_vld, r_abort;
    logic [LOW_DATA_WIDTH-1:0] r_out_dat;

    logic [N_REQ-1:0]          w_pick_gnt;
    logic [IW-1:0]             w_pick_idx;
    logic                      w_pick_any, w_xfer, w_last, w_stall_hit, w_release;
    logic [LOW_DATA_WIDTH-1:0] w_byte;
    logic [8:0]                w_units;
    logic [CW-1:0]             w_total;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign bus.req_ready = (r_state != ST_IDLE) ? r_grant : '0;
    assign w_xfer        = |(bus.req_valid & bus.req_ready);
    assign w_byte        = bus.req_data[r_idx*LOW_DATA_WIDTH +: LOW_DATA_WIDTH];

    // A length byte of zero stands for 256 burst units.
    assign w_units     = (r_len == 8'd0) ? 9'd256 : {1'b0, r_len};
    assign w_total     = CW'(w_units * UNIT_BYTES);
    assign w_last      = (r_byte_cnt == w_total - CW'(1));
    assign w_stall_hit = (TIMEOUT != 0) && !w_xfer && (r_stall_cnt == SW'(TIMEOUT - 1));
    assign w_release   = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_pick_any) w_state_nxt = ST_CMD;
            ST_CMD:     if (w_xfer) w_state_nxt = (w_byte == LOW_DATA_WIDTH'(CMD_DATA_TRAN))
                                                  ? ST_ADDR_LO : ST_ORDER;
            ST_ADDR_LO: if (w_xfer) w_state_nxt = ST_ADDR_HI;
            ST_ADDR_HI: if (w_xfer) w_state_nxt = ST_LEN;
            ST_LEN:     if (w_xfer) w_state_nxt = ST_DATA;
            ST_DATA:    if (w_xfer && w_last) w_state_nxt = ST_IDLE;
            ST_ORDER:   if (w_xfer) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if ((r_state != ST_IDLE) && w_stall_hit) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_rr_ptr    <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_stall_cnt <= '0;
            r_out_vld   <= 1'b0;
            r_out_dat   <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_vld <= w_xfer;
            r_abort   <= (r_state != ST_IDLE) && w_stall_hit;
            if (w_xfer) r_out_dat <= w_byte;

            if (r_state == ST_IDLE) begin
                r_stall_cnt <= '0;
                if (w_pick_any) begin
                    r_grant <= w_pick_gnt;
                    r_idx   <= w_pick_idx;
                end
            end else begin
                r_stall_cnt <= w_xfer ? '0 : r_stall_cnt + 1'b1;
            end

            // Normal completion and watchdog drop both hand priority to the next index.
            if (w_release) begin
                r_grant  <= '0;
                r_rr_ptr <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
            end

            if ((r_state == ST_LEN) && w_xfer) begin
                r_len      <= w_byte[7:0];
                r_byte_cnt <= '0;
            end else if ((r_state == ST_DATA) && w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    assign bus.grant          = r_grant;
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.low_read_valid = r_out_vld;
    assign bus.low_read_data  = r_out_dat;
    assign bus.abort          = r_abort;
endmodule

// File: tb/tb_low_bus_arbiter.sv
// Drives queued packets into two arbiters (watchdog 255 and 4) and compares every
// cycle against a packet-level model of grant, forwarding and watchdog behaviour.
module tb_low_bus_arbiter;
    localparam int N    = 4;
    localparam int W    = 8;
    localparam int UNIT = 4;
    localparam int TMO0 = 255;
    localparam int TMO1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    low_bus_arbiter_if #(.N_REQ(N), .LOW_DATA_WIDTH(W)) bus0 ();
    low_bus_arbiter_if #(.N_REQ(N), .LOW_DATA_WIDTH(W)) bus1 ();

    low_bus_arbiter #(.LOW_DATA_WIDTH(W), .BRUST_SIZE_LOG(2), .N_REQ(N),
                      .CMD_DATA_TRAN(8'hA5), .TIMEOUT(TMO0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    low_bus_arbiter #(.LOW_DATA_WIDTH(W), .BRUST_SIZE_LOG(2), .N_REQ(N),
                      .CMD_DATA_TRAN(8'hA5), .TIMEOUT(TMO1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    // Requester side: bytes still to send and the idle cycles before each one.
    logic [7:0] rq   [N][$];
    int         rgap [N][$];
    logic [N-1:0] v;
    logic [7:0]   d [N];

    // Model: owner (-1 = bus free), bytes taken in the current packet, etc.
    int         m_owner, m_rr, m_stall, m_k, m_len;
    logic [7:0] m_b0, m_dat;
    logic       m_vld, m_abort;
    int obs_bytes, obs_aborts, exp_bytes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tmo();
        return (sel == 0) ? TMO0 : TMO1;
    endfunction

    function automatic int rg();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    function automatic bit pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += rq[i].size();
        return (s > 0) || (m_owner >= 0);
    endfunction

    task automatic check_outputs();
        logic [N-1:0] g, rdy, eg;
        logic vld, bsy, ab;
        logic [7:0] dat;
        if (sel == 0) begin
            g = bus0.grant; rdy = bus0.req_ready; vld = bus0.low_read_valid;
            dat = bus0.low_read_data; bsy = bus0.busy; ab = bus0.abort;
        end else begin
            g = bus1.grant; rdy = bus1.req_ready; vld = bus1.low_read_valid;
            dat = bus1.low_read_data; bsy = bus1.busy; ab = bus1.abort;
        end
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        chk("grant",          32'(g),   32'(eg));
        chk("req_ready",      32'(rdy), 32'(eg));
        chk("busy",           32'(bsy), 32'(m_owner >= 0));
        chk("low_read_valid", 32'(vld), 32'(m_vld));
        chk("low_read_data",  32'(dat), 32'(m_dat));
        chk("abort",          32'(ab),  32'(m_abort));
        if (vld === 1'b1) obs_bytes++;
        if (ab === 1'b1) obs_aborts++;
    endtask

    task automatic drive_inputs();
        logic [N*W-1:0] dd;
        dd = '0;
        for (int i = 0; i < N; i++) begin
            d[i] = 8'($urandom);
            v[i] = 1'b0;
            if (rq[i].size() > 0) begin
                if (rgap[i][0] > 0) rgap[i][0] = rgap[i][0] - 1;
                else begin
                    v[i] = 1'b1;
                    d[i] = rq[i][0];
                end
            end
            dd[i*W +: W] = d[i];
        end
        bus0.req_valid = (sel == 0) ? v : '0;
        bus0.req_data  = (sel == 0) ? dd : '0;
        bus1.req_valid = (sel == 1) ? v : '0;
        bus1.req_data  = (sel == 1) ? dd : '0;
    endtask

    task automatic model_edge();
        int j;
        if (rst) begin
            m_owner = -1; m_rr = 0; m_stall = 0; m_k = 0;
            m_vld = 1'b0; m_dat = 8'h00; m_abort = 1'b0;
            return;
        end
        m_vld = 1'b0;
        m_abort = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (m_owner < 0 && v[j]) begin
                    m_owner = j; m_k = 0; m_stall = 0;
                end
            end
        end else if (v[m_owner]) begin
            m_vld = 1'b1;
            m_dat = d[m_owner];
            void'(rq[m_owner].pop_front());
            void'(rgap[m_owner].pop_front());
            if (m_k == 0) m_b0 = m_dat;
            if (m_k == 3) m_len = int'(m_dat);
            m_k++;
            m_stall = 0;
            if ((m_b0 != 8'hA5 && m_k == 2) ||
                (m_b0 == 8'hA5 && m_k >= 4 && m_k == 4 + UNIT * ((m_len == 0) ? 256 : m_len))) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            m_stall++;
            if (tmo() != 0 && m_stall == tmo()) begin
                m_abort = 1'b1;
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic step();
        check_outputs();
        drive_inputs();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        step();
        step();
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic begin_scn();
        obs_bytes = 0; obs_aborts = 0; exp_bytes = 0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            rgap[i].delete();
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] b, input int gap);
        rq[r].push_back(b);
        rgap[r].push_back(gap);
        exp_bytes++;
    endtask

    task automatic push_burst(input int r, input logic [7:0] len, input logic [15:0] addr,
                              input bit rnd, input int stall_idx, input int stall_len);
        int units;
        push_byte(r, 8'hA5, rnd ? rg() : 0);
        push_byte(r, addr[7:0], rnd ? rg() : 0);
        push_byte(r, addr[15:8], rnd ? rg() : 0);
        push_byte(r, len, rnd ? rg() : 0);
        units = (len == 8'd0) ? 256 : int'(len);
        for (int k = 0; k < units * UNIT; k++)
            push_byte(r, 8'($urandom), (k == stall_idx) ? stall_len : (rnd ? rg() : 0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, r;
        logic [7:0] c;
        rst = 1'b1;
        sel = 0;
        v = '0;
        bus0.req_valid = '0; bus0.req_data = '0;
        bus1.req_valid = '0; bus1.req_data = '0;
        clear_queues();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;

        // Single burst from req0.
        begin_scn();
        push_burst(0, 8'h02, 16'h1234, 1'b0, -1, 0);
        run_drain(100);
        chk("s1_bytes", 32'(obs_bytes), 32'(exp_bytes));

        // Order packet from req2, then req0/req3 contend: rr pointer at 3 picks req3.
        begin_scn();
        push_byte(2, 8'h3C, 0);
        push_byte(2, 8'h7F, 0);
        run_drain(50);
        chk("order_bytes", 32'(obs_bytes), 32'd2);
        begin_scn();
        push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0);
        push_byte(3, 8'h33, 0); push_byte(3, 8'h44, 0);
        run_drain(50);
        chk("rr3_bytes", 32'(obs_bytes), 32'(exp_bytes));

        // Reset in the middle of a data phase.
        begin_scn();
        push_burst(1, 8'h04, 16'h5678, 1'b0, -1, 0);
        n = 0;
        while (!(m_owner == 1 && m_k >= 6) && n < 50) begin
            step();
            n++;
        end
        chk("reached_data", 32'(n < 50), 32'd1);
        rst = 1'b1;
        step();
        clear_queues();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(bus0.busy), 32'd0);

        // Three-way contention from rr pointer 0: expect 0, 1, 3.
        begin_scn();
        push_burst(0, 8'h01, 16'h0000, 1'b0, -1, 0);
        push_burst(1, 8'h01, 16'h1111, 1'b0, -1, 0);
        push_burst(3, 8'h01, 16'h3333, 1'b0, -1, 0);
        run_drain(100);
        chk("contention_bytes", 32'(obs_bytes), 32'd24);

        // Five-cycle stall inside the data phase, well under the watchdog.
        begin_scn();
        push_burst(1, 8'h02, 16'hBEEF, 1'b0, 3, 5);
        run_drain(100);
        chk("stall_bytes", 32'(obs_bytes), 32'd12);
        chk("stall_aborts", 32'(obs_aborts), 32'd0);

        // Length 0 means 256 units = 1024 data bytes.
        begin_scn();
        push_burst(2, 8'h00, 16'h0F0F, 1'b0, -1, 0);
        run_drain(1200);
        chk("wrap_bytes", 32'(obs_bytes), 32'd1028);

        // Random packets on all requesters with random gaps.
        begin_scn();
        for (int p = 0; p < 24; p++) begin
            r = int'($urandom_range(0, N - 1));
            if ($urandom_range(0, 2) == 0) begin
                c = 8'($urandom);
                if (c == 8'hA5) c = 8'h5A;
                push_byte(r, c, rg());
                push_byte(r, 8'($urandom), rg());
            end else begin
                push_burst(r, 8'($urandom_range(1, 6)), 16'($urandom), 1'b1, -1, 0);
            end
        end
        run_drain(4000);
        chk("random_bytes", 32'(obs_bytes), 32'(exp_bytes));

        // Switch to the short-watchdog instance.
        rst = 1'b1;
        step();
        sel = 1;
        rst = 1'b0;

        // req0 dies after its length byte; req1 is waiting and takes over.
        begin_scn();
        push_byte(0, 8'hA5, 0); push_byte(0, 8'h00, 0);
        push_byte(0, 8'h00, 0); push_byte(0, 8'h01, 0);
        push_byte(1, 8'h3C, 0); push_byte(1, 8'h01, 0);
        run_drain(100);
        chk("tmo_bytes", 32'(obs_bytes), 32'd6);
        chk("tmo_aborts", 32'(obs_aborts), 32'd1);

        // A stall of one cycle less than the watchdog survives.
        begin_scn();
        push_burst(2, 8'h01, 16'h2222, 1'b0, 1, TMO1 - 1);
        run_drain(100);
        chk("tmo_edge_bytes", 32'(obs_bytes), 32'd8);
        chk("tmo_edge_aborts", 32'(obs_aborts), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
